inference_frame_dispatcher: RTL and testbench

- Sits between the UDP receive path and a pool of NUM_ENGINES inference engines.
- On each received-frame pulse, captures the frame and its source addressing, then launches the frame on a free engine chosen round-robin.
- Remembers which requester owns each engine (source IP, MAC and UDP port).
- Arbitrates completed engine results onto a single valid/ready stream toward the transmit path. Frames that arrive while every engine is busy are dropped.

---
 rtl/infernet_dispatch_pkg.sv | 21 ++
 rtl/inference_frame_dispatcher_rr_arbiter.sv | 31 +++
 rtl/inference_frame_dispatcher.sv | 144 ++++++++++++++
 tb/tb_inference_frame_dispatcher.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/infernet_dispatch_pkg.sv
// Shared types for the inference frame dispatcher: slot lifecycle states,
// the requester context remembered per engine, and address field widths.
package infernet_dispatch_pkg;

   localparam int IP_ADDR_WIDTH  = 32;
   localparam int MAC_ADDR_WIDTH = 48;
   localparam int UDP_PORT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PENDING = 2'd2
   } slot_state_t;

   typedef struct packed {
      logic [IP_ADDR_WIDTH-1:0]  ip;
      logic [MAC_ADDR_WIDTH-1:0] mac;
      logic [UDP_PORT_WIDTH-1:0] udp_port;
   } requester_ctx_t;

endpackage

// File: rtl/inference_frame_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), zero latency, no internal state.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       grant_vld
);

   int                         s;
   logic [$clog2(NUM_REQ)-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      s         = 0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         s = int'(ptr) + k;
         if (s >= NUM_REQ) s = s - NUM_REQ;
         idx = $clog2(NUM_REQ)'(s);
         if (!grant_vld && req[idx]) begin
            grant[idx] = 1'b1;
            grant_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/inference_frame_dispatcher.sv
// Launches received frames on free engines round-robin (START one cycle after RX), and
// returns results via a one-entry valid/ready TX stage; optional DISPATCH_STATS_EN counters.
module inference_frame_dispatcher
   import infernet_dispatch_pkg::*;
#(
   parameter int NUM_ENGINES     = 4,
   parameter int USER_DATA_BYTES = 785,
   parameter int RESULT_WIDTH    = 8
) (
   input  logic                                ACLK,
   input  logic                                ARESET,
   input  logic                                RX_FRAME_READY,
   input  logic [USER_DATA_BYTES*8-1:0]        RX_DATA_FRAME,
   input  logic [IP_ADDR_WIDTH-1:0]            RX_SRC_IP_ADDRESS,
   input  logic [MAC_ADDR_WIDTH-1:0]           RX_SRC_MAC_ADDRESS,
   input  logic [UDP_PORT_WIDTH-1:0]           RX_SRC_UDP_PORT,
   output logic [NUM_ENGINES-1:0]              ENG_START,
   output logic [USER_DATA_BYTES*8-1:0]        ENG_FRAME,
   input  logic [NUM_ENGINES-1:0]              ENG_BUSY,
   input  logic [NUM_ENGINES-1:0]              ENG_DONE,
   input  logic [NUM_ENGINES*RESULT_WIDTH-1:0] ENG_RESULT,
   output logic                                TX_VALID,
   input  logic                                TX_READY,
   output logic [RESULT_WIDTH-1:0]             TX_RESULT,
   output logic [IP_ADDR_WIDTH-1:0]            TX_DST_IP_ADDRESS,
   output logic [MAC_ADDR_WIDTH-1:0]           TX_DST_MAC_ADDRESS,
   output logic [UDP_PORT_WIDTH-1:0]           TX_DST_UDP_PORT
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]                         DISPATCH_COUNT,
   output logic [31:0]                         DROP_COUNT
`endif
);

   localparam int IDX_W = $clog2(NUM_ENGINES);

   slot_state_t             state  [NUM_ENGINES];
   requester_ctx_t          ctx    [NUM_ENGINES];
   logic [RESULT_WIDTH-1:0] result [NUM_ENGINES];

   logic [IDX_W-1:0]       disp_ptr, res_ptr, disp_sel, res_sel;
   logic [NUM_ENGINES-1:0] eligible, pending, disp_grant, res_grant;
   logic                   disp_vld, res_vld, tx_load;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_ENGINES - 1) ? '0 : i + 1'b1;
   endfunction

   // Decisions use registered slot state only, so a slot freed this cycle is usable next cycle.
   always_comb begin
      eligible = '0;
      pending  = '0;
      disp_sel = '0;
      res_sel  = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         eligible[i] = (state[i] == IDLE) && !ENG_BUSY[i];
         pending[i]  = (state[i] == PENDING);
         if (disp_grant[i]) disp_sel = IDX_W'(i);
         if (res_grant[i])  res_sel  = IDX_W'(i);
      end
   end

   assign tx_load = !TX_VALID || TX_READY;

   rr_arbiter #(.NUM_REQ(NUM_ENGINES)) u_disp_arb (
      .req       (eligible),
      .ptr       (disp_ptr),
      .grant     (disp_grant),
      .grant_vld (disp_vld)
   );

   rr_arbiter #(.NUM_REQ(NUM_ENGINES)) u_res_arb (
      .req       (pending),
      .ptr       (res_ptr),
      .grant     (res_grant),
      .grant_vld (res_vld)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ENG_START          <= '0;
         ENG_FRAME          <= '0;
         disp_ptr           <= '0;
         res_ptr            <= '0;
         TX_VALID           <= 1'b0;
         TX_RESULT          <= '0;
         TX_DST_IP_ADDRESS  <= '0;
         TX_DST_MAC_ADDRESS <= '0;
         TX_DST_UDP_PORT    <= '0;
         for (int i = 0; i < NUM_ENGINES; i++) begin
            state[i]  <= IDLE;
            ctx[i]    <= '0;
            result[i] <= '0;
         end
      end else begin
         ENG_START <= '0;
         if (RX_FRAME_READY && disp_vld) begin
            ENG_START <= disp_grant;
            ENG_FRAME <= RX_DATA_FRAME;
            disp_ptr  <= next_idx(disp_sel);
         end

         // Dispatch, completion and TX retirement act on disjoint states, so at most one fires per slot.
         for (int i = 0; i < NUM_ENGINES; i++) begin
            if (RX_FRAME_READY && disp_grant[i]) begin
               state[i] <= RUNNING;
               ctx[i]   <= '{ip: RX_SRC_IP_ADDRESS, mac: RX_SRC_MAC_ADDRESS,
                             udp_port: RX_SRC_UDP_PORT};
            end else if (ENG_DONE[i] && state[i] == RUNNING) begin
               state[i]  <= PENDING;
               result[i] <= ENG_RESULT[i*RESULT_WIDTH +: RESULT_WIDTH];
            end else if (tx_load && res_grant[i]) begin
               state[i] <= IDLE;
            end
         end

         if (tx_load) begin
            TX_VALID <= res_vld;
            if (res_vld) begin
               TX_RESULT          <= result[res_sel];
               TX_DST_IP_ADDRESS  <= ctx[res_sel].ip;
               TX_DST_MAC_ADDRESS <= ctx[res_sel].mac;
               TX_DST_UDP_PORT    <= ctx[res_sel].udp_port;
               res_ptr            <= next_idx(res_sel);
            end
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         DISPATCH_COUNT <= '0;
         DROP_COUNT     <= '0;
      end else begin
         if (ENG_START != '0 && DISPATCH_COUNT != '1)
            DISPATCH_COUNT <= DISPATCH_COUNT + 32'd1;
         if (RX_FRAME_READY && !disp_vld && DROP_COUNT != '1)
            DROP_COUNT <= DROP_COUNT + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inference_frame_dispatcher.sv
// Randomized and directed bench for inference_frame_dispatcher against a slot-level
// behavioural model; outputs are compared on every falling edge.
`timescale 1ns/1ps
module tb_inference_frame_dispatcher;

   localparam int N  = 4;
   localparam int RW = 8;
   localparam int FW = 785 * 8;
   localparam int S_IDLE = 0, S_RUN = 1, S_PEND = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            areset, rx_rdy, tx_ready, tx_valid;
   logic [FW-1:0]   rx_frame, eng_frame;
   logic [31:0]     rx_ip, tx_ip;
   logic [47:0]     rx_mac, tx_mac;
   logic [15:0]     rx_port, tx_port;
   logic [N-1:0]    eng_start, eng_busy, eng_done;
   logic [N*RW-1:0] eng_result;
   logic [RW-1:0]   tx_result;
`ifdef DISPATCH_STATS_EN
   logic [31:0]     disp_cnt, drop_cnt;
`endif

   inference_frame_dispatcher #(.NUM_ENGINES(N), .USER_DATA_BYTES(785), .RESULT_WIDTH(RW)) dut (
      .ACLK(clk), .ARESET(areset), .RX_FRAME_READY(rx_rdy), .RX_DATA_FRAME(rx_frame),
      .RX_SRC_IP_ADDRESS(rx_ip), .RX_SRC_MAC_ADDRESS(rx_mac), .RX_SRC_UDP_PORT(rx_port),
      .ENG_START(eng_start), .ENG_FRAME(eng_frame), .ENG_BUSY(eng_busy), .ENG_DONE(eng_done),
      .ENG_RESULT(eng_result), .TX_VALID(tx_valid), .TX_READY(tx_ready), .TX_RESULT(tx_result),
      .TX_DST_IP_ADDRESS(tx_ip), .TX_DST_MAC_ADDRESS(tx_mac), .TX_DST_UDP_PORT(tx_port)
`ifdef DISPATCH_STATS_EN
      , .DISPATCH_COUNT(disp_cnt), .DROP_COUNT(drop_cnt)
`endif
   );

   int n_total = 0;
   int n_pass  = 0;
   bit cmp_en  = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic chk_frame(input string name, input logic [FW-1:0] exp);
      n_total++;
      if (eng_frame === exp) n_pass++;
      else $display("FAIL %s: got ..%0h want ..%0h", name, eng_frame[63:0], exp[63:0]);
   endtask

   // ---------------- behavioural model ----------------
   int          m_st [N];
   bit [31:0]   m_ip [N];
   bit [47:0]   m_mac [N];
   bit [15:0]   m_port [N];
   bit [RW-1:0] m_res [N];
   int          m_p, m_r, m_dsel, m_tsel, m_j;
   bit          m_load;
   bit [N-1:0]  m_fin, m_start;
   bit [FW-1:0] m_frame;
   bit          m_tv;
   bit [RW-1:0] m_tr;
   bit [31:0]   m_tip, m_disp, m_drops;
   bit [47:0]   m_tmac;
   bit [15:0]   m_tport;

   always @(posedge clk) begin
      if (areset) begin
         for (int i = 0; i < N; i++) m_st[i] = S_IDLE;
         m_p = 0; m_r = 0; m_start = '0; m_frame = '0; m_tv = 0;
         m_tr = '0; m_tip = '0; m_tmac = '0; m_tport = '0; m_disp = 0; m_drops = 0;
      end else begin
         // every decision below looks only at the slot states from before this edge
         m_dsel = -1;
         m_tsel = -1;
         m_load = !m_tv || tx_ready;
         for (int k = 0; k < N; k++) begin
            m_j = (m_p + k) % N;
            if (rx_rdy && m_dsel < 0 && m_st[m_j] == S_IDLE && !eng_busy[m_j]) m_dsel = m_j;
            m_j = (m_r + k) % N;
            if (m_load && m_tsel < 0 && m_st[m_j] == S_PEND) m_tsel = m_j;
         end
         for (int i = 0; i < N; i++) m_fin[i] = eng_done[i] && m_st[i] == S_RUN;
         if (m_start != '0) m_disp++;
         m_start = '0;
         if (rx_rdy && m_dsel >= 0) begin
            m_start[m_dsel] = 1'b1;
            m_frame = rx_frame;
            m_st[m_dsel] = S_RUN;
            m_ip[m_dsel] = rx_ip; m_mac[m_dsel] = rx_mac; m_port[m_dsel] = rx_port;
            m_p = (m_dsel + 1) % N;
         end else if (rx_rdy) begin
            m_drops++;
         end
         for (int i = 0; i < N; i++)
            if (m_fin[i]) begin
               m_st[i] = S_PEND;
               m_res[i] = eng_result[i*RW +: RW];
            end
         if (m_load) begin
            m_tv = (m_tsel >= 0);
            if (m_tsel >= 0) begin
               m_tr = m_res[m_tsel]; m_tip = m_ip[m_tsel];
               m_tmac = m_mac[m_tsel]; m_tport = m_port[m_tsel];
               m_st[m_tsel] = S_IDLE;
               m_r = (m_tsel + 1) % N;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("start", 128'(eng_start), 128'(m_start));
         chk("tx_valid", 128'(tx_valid), 128'(m_tv));
         if (m_start != '0) chk_frame("frame", m_frame);
         if (m_tv) chk("tx_fields", 128'({tx_result, tx_ip, tx_mac, tx_port}),
                       128'({m_tr, m_tip, m_tmac, m_tport}));
`ifdef DISPATCH_STATS_EN
         chk("disp_cnt", 128'(disp_cnt), 128'(m_disp));
         chk("drop_cnt", 128'(drop_cnt), 128'(m_drops));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      f = '0;
      for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom();
      for (int b = (FW / 32) * 32; b < FW; b++) f[b] = 1'($urandom());
      return f;
   endfunction

   task automatic drive_frame(input logic [31:0] ip, input logic [15:0] port);
      rx_ip = ip; rx_port = port; rx_mac = {16'h02AA, ip};
      rx_frame = rand_frame();
      rx_rdy = 1'b1;
   endtask

   task automatic do_reset();
      areset = 1'b1; rx_rdy = 1'b0; eng_done = '0; eng_busy = '0; tx_ready = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      areset = 1'b0;
   endtask

   initial begin
      areset = 1'b1; rx_rdy = 1'b0; rx_frame = '0; rx_ip = '0; rx_mac = '0; rx_port = '0;
      eng_busy = '0; eng_done = '0; eng_result = '0; tx_ready = 1'b1;

      // single frame round trip
      do_reset();
      chk("rst_start", 128'(eng_start), 128'(0));
      chk("rst_tx_valid", 128'(tx_valid), 128'(0));
      chk("rst_frame", 128'(eng_frame[127:0]), 128'(0));
      drive_frame(32'h0A000005, 16'd5000); tick(); rx_rdy = 1'b0;
      chk("t1_start", 128'(eng_start), 128'(4'b0001));
      eng_done = 4'b0001; eng_result = 32'h0000_0007; tick(); eng_done = '0;
      chk("t1_tx_early", 128'(tx_valid), 128'(0));
      tick();
      chk("t1_tx_valid", 128'(tx_valid), 128'(1));
      chk("t1_result", 128'(tx_result), 128'(8'h07));
      chk("t1_ip", 128'(tx_ip), 128'(32'h0A000005));
      chk("t1_port", 128'(tx_port), 128'(16'd5000));
      tick();
      chk("t1_drained", 128'(tx_valid), 128'(0));

      // five back-to-back frames, fifth dropped
      do_reset();
      for (int f = 0; f < 5; f++) begin
         drive_frame(32'h0A000100 + 32'(f), 16'(6000 + f)); tick();
         chk("t2_start", 128'(eng_start), (f < 4) ? 128'(1) << f : 128'(0));
         if (f < 4) chk_frame("t2_frame", rx_frame);
      end
      rx_rdy = 1'b0;
`ifdef DISPATCH_STATS_EN
      chk("t2_drops", 128'(drop_cnt), 128'(1));
`endif
      tick();

      // busy engine skipped, pointer advances past the chosen slot
      do_reset();
      drive_frame(32'h0A000200, 16'd1); tick(); rx_rdy = 1'b0;
      chk("t3_first", 128'(eng_start), 128'(4'b0001));
      eng_busy = 4'b0010; drive_frame(32'h0A000201, 16'd2); tick(); rx_rdy = 1'b0;
      chk("t3_skip_busy", 128'(eng_start), 128'(4'b0100));
      eng_busy = '0; drive_frame(32'h0A000202, 16'd3); tick(); rx_rdy = 1'b0;
      chk("t3_ptr3", 128'(eng_start), 128'(4'b1000));
      tick();

      // simultaneous completions with r=1 and a stalled TX
      do_reset();
      for (int e = 0; e < 3; e++) begin
         drive_frame(32'h0A000300 + 32'(e), 16'(7000 + e)); tick();
         chk("t4_fill", 128'(eng_start), 128'(1) << e);
      end
      rx_rdy = 1'b0;
      eng_done = 4'b0001; eng_result = 32'h0000_0011; tick(); eng_done = '0; tick();
      chk("t4_first_res", 128'(tx_result), 128'(8'h11));
      tick();
      drive_frame(32'h0A000303, 16'd7003); tick();
      chk("t4_e3", 128'(eng_start), 128'(4'b1000));
      drive_frame(32'h0A000304, 16'd7004); tick(); rx_rdy = 1'b0;
      chk("t4_e0_again", 128'(eng_start), 128'(4'b0001));
      tx_ready = 1'b0; eng_done = 4'b0101; eng_result = 32'h0022_0033; tick(); eng_done = '0; tick();
      for (int s = 0; s < 3; s++) begin
         chk("t4_stall_valid", 128'(tx_valid), 128'(1));
         chk("t4_stall_res", 128'({tx_result, tx_ip}), 128'({8'h22, 32'h0A000302}));
         tick();
      end
      tx_ready = 1'b1;
      chk("t4_stall_last", 128'(tx_result), 128'(8'h22));
      tick();
      chk("t4_second", 128'({tx_valid, tx_result, tx_ip}), 128'({1'b1, 8'h33, 32'h0A000304}));
      tick();
      chk("t4_empty", 128'(tx_valid), 128'(0));

      // spurious completion on an idle slot
      do_reset();
      eng_done = 4'b1000; eng_result = 32'h5500_0000; tick(); eng_done = '0;
      for (int s = 0; s < 3; s++) begin
         chk("t5_no_tx", 128'(tx_valid), 128'(0));
         tick();
      end
      for (int e = 0; e < 4; e++) begin
         drive_frame(32'h0A000500 + 32'(e), 16'd9); tick();
         chk("t5_slot_idle", 128'(eng_start), 128'(1) << e);
      end
      rx_rdy = 1'b0; tick();

      // reset mid-operation discards contexts and pending output
      do_reset(); tx_ready = 1'b0;
      for (int e = 0; e < 3; e++) begin
         drive_frame(32'h0A000600 + 32'(e), 16'd11); tick();
      end
      rx_rdy = 1'b0;
      eng_done = 4'b0001; tick(); eng_done = '0; tick();
      chk("t6_pre_valid", 128'(tx_valid), 128'(1));
      areset = 1'b1; drive_frame(32'h0A000609, 16'd12); tick(); areset = 1'b0; rx_rdy = 1'b0;
      chk("t6_rst", 128'({tx_valid, eng_start}), 128'(0));
      eng_done = 4'b0110; tick(); eng_done = '0;
      for (int s = 0; s < 3; s++) begin
         chk("t6_no_tx", 128'(tx_valid), 128'(0));
         tick();
      end

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         areset = ($urandom_range(499, 0) == 0);
         rx_rdy = 1'b0;
         if ($urandom_range(9, 0) < 4) drive_frame($urandom(), 16'($urandom()));
         for (int i = 0; i < N; i++) begin
            eng_busy[i] = ($urandom_range(7, 0) == 0);
            eng_done[i] = ($urandom_range(9, 0) < 3);
         end
         eng_result = $urandom();
         tx_ready = ($urandom_range(9, 0) < 6);
         tick();
      end
      areset = 1'b0; rx_rdy = 1'b0; eng_done = '0; eng_busy = '0; tx_ready = 1'b1;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
